miriscv_data_ram_resp: RTL and testbench
========================================

Name: miriscv_data_ram_resp

Overview:
- Responder (memory side) of the core's data memory interface: req/we/be/addr/wdata in, rvalid/rdata out.
- Word-organised, byte-writable on-chip data RAM with a configurable fixed response latency.
- Sits in the SoC between the core's data port and nothing else; serves as the data memory for simulation and FPGA builds.
- Adds an out-of-range error flag and a request counter for bring-up and verification.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- DEPTH_WORDS, 1024, number of XLEN-bit words; must be a power of two.
- LATENCY, 1, cycles from request acceptance to data_rvalid_o; legal range 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- data_req_i  in  1  request strobe; one request is accepted per cycle while high.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  XLEN/8  byte enables for writes, already lane-aligned by the LSU.
- data_addr_i  in  XLEN  byte address.
- data_wdata_i  in  XLEN  write data, already lane-aligned.
- data_rvalid_o  out  1  response valid, one pulse per accepted request.
- data_rdata_o  out  XLEN  full read word; 0 for write responses.
- data_err_o  out  1  qualifies data_rvalid_o; the address was out of range.
- req_cnt_o  out  32  number of accepted requests, saturating.

Behaviour:
- Always ready; there is no grant. Every cycle with data_req_i=1 is an accepted request, and back-to-back requests are legal.
- Decode:
  - off = data_addr_i - BASE_ADDR
  - idx = off[log2(DEPTH_WORDS)+1:2]
  - in_range = (off >> 2) < DEPTH_WORDS
  - addr[1:0] is ignored.
- Write: at the acceptance edge, for each i with data_be_i[i]=1 and in_range, mem[idx] byte i <= data_wdata_i byte i. be=0 leaves memory unchanged but still produces a response.
- Read: the word is sampled at the acceptance edge. It reflects every write accepted in an earlier cycle, so a read in the cycle after a write to the same address returns the new data.
- Out-of-range request: no memory change. The response carries data_err_o=1 and data_rdata_o=0.
- Response pipeline: a LATENCY-deep shift register of {valid, err, rdata}.
  - data_rvalid_o rises exactly LATENCY cycles after the acceptance cycle and lasts one cycle per request.
  - Responses come back in request order.
  - With back-to-back requests, rvalid stays high for consecutive cycles.
- Outputs when data_rvalid_o=0: data_rdata_o=0 and data_err_o=0.
- req_cnt_o increments by 1 on each accepted request and saturates at 32'hFFFF_FFFF.
- Reset (rst_i=1 at a clock edge):
  - data_rvalid_o=0, data_rdata_o=0, data_err_o=0, req_cnt_o=0.
  - The whole pipeline is cleared, so in-flight responses are dropped and never emitted.
  - Memory contents are not cleared.
  - A request presented while rst_i=1 is ignored: no write, no response, no count.
- Reset mid-operation: a write accepted before the reset edge stays committed. Its response is lost if it had not yet been emitted.
- Address at the boundaries:
  - BASE_ADDR+4*DEPTH_WORDS-4 is the last valid word.
  - BASE_ADDR+4*DEPTH_WORDS is an error.
  - An address below BASE_ADDR wraps to a large off and is an error.
- Memory is inferable as block RAM: one synchronous read/write port. LATENCY>1 stages are output registers only.

Test Plan:
- Reset with LATENCY=1: hold rst_i 2 cycles, then issue no requests -> all outputs 0 and req_cnt_o=0; issue a request during rst_i -> no rvalid, count stays 0.
- Write/read: write addr 0x10, be=4'hF, wdata=0xDEADBEEF; read 0x10 on the next cycle -> rvalid 1 cycle after each request; read rdata=0xDEADBEEF; err=0; req_cnt_o=2.
- Byte enables: write 0x20=0x11223344 (be=F), then write 0x20 wdata=0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
- LATENCY=3, back-to-back reads of 0x0, 0x4, 0x8 preloaded with 1, 2, 3 -> rvalid high for 3 consecutive cycles starting 3 cycles after the first request; data 1, 2, 3 in order.
- Range, DEPTH_WORDS=1024, BASE=0: read 0xFFC succeeds; write 0x1000 then read 0x1000 -> both responses have err=1 and rdata=0; memory is unchanged.
- Reset mid-flight, LATENCY=4: write 0x40=0x5A5A5A5A, assert rst_i 2 cycles later -> no rvalid is emitted; a later read of 0x40 returns 0x5A5A5A5A.

Source files
------------

// File: rtl/miriscv_data_ram_resp.sv
// -----------------------------------------------------------------------------
// miriscv_data_ram_resp
//
// Memory-side responder for the core's data port: a word-organised,
// byte-writable on-chip RAM that answers every request after a fixed
// number of cycles.
//
// There is no grant. Every cycle with data_req_i high is an accepted request.
// Requests whose address falls outside the RAM window do not touch memory.
// Their response carries data_err_o=1 and zero data.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset; clears the response
//                  pipeline and the counter, leaves memory contents intact
//   data_req_i     request strobe
//   data_we_i      1 = write, 0 = read
//   data_be_i      per-byte write enables (lane aligned)
//   data_addr_i    byte address (bits [1:0] ignored)
//   data_wdata_i   write data (lane aligned)
//   data_rvalid_o  one-cycle response pulse per accepted request
//   data_rdata_o   read word; 0 for writes, errors and idle cycles
//   data_err_o     response address was out of range
//   req_cnt_o      saturating count of accepted requests
// -----------------------------------------------------------------------------
module miriscv_data_ram_resp #(
   parameter int unsigned      XLEN        = 32,
   parameter int unsigned      DEPTH_WORDS = 1024,
   parameter int unsigned      LATENCY     = 1,
   parameter logic [XLEN-1:0]  BASE_ADDR   = 32'h0000_0000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [XLEN/8-1:0] data_be_i,
   input  logic [XLEN-1:0]   data_addr_i,
   input  logic [XLEN-1:0]   data_wdata_i,
   output logic              data_rvalid_o,
   output logic [XLEN-1:0]   data_rdata_o,
   output logic              data_err_o,
   output logic [31:0]       req_cnt_o
);

   localparam int IDX_W  = $clog2(DEPTH_WORDS);
   localparam int NBYTES = XLEN / 8;

   logic [XLEN-1:0] off;
   logic [IDX_W-1:0] idx;
   logic            in_range;
   logic            do_write;
   logic            do_read;

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   logic            pipe_valid [LATENCY];
   logic            pipe_err   [LATENCY];
   logic [XLEN-1:0] pipe_rdata [LATENCY];

   logic [31:0]     req_cnt;

   // Address decode. An address below BASE_ADDR wraps to a huge offset and
   // therefore fails the range test without a separate comparison.
   always_comb begin
      off      = data_addr_i - BASE_ADDR;
      idx      = off[IDX_W+1:2];
      in_range = (off >> 2) < XLEN'(DEPTH_WORDS);
      do_write = data_req_i & ~rst_i & data_we_i & in_range;
      do_read  = data_req_i & ~rst_i & ~data_we_i & in_range;
   end

   // Byte-masked write port. No reset, so the array maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (do_write) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (data_be_i[i]) begin
               mem[idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
            end
         end
      end
   end

   // Response pipeline. Stage 0 holds the synchronous RAM read.
   // Any further stages are plain delay registers that keep responses in order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < int'(LATENCY); s++) begin
            pipe_valid[s] <= 1'b0;
            pipe_err[s]   <= 1'b0;
            pipe_rdata[s] <= {XLEN{1'b0}};
         end
      end else begin
         pipe_valid[0] <= data_req_i;
         pipe_err[0]   <= data_req_i & ~in_range;
         pipe_rdata[0] <= do_read ? mem[idx] : {XLEN{1'b0}};
         for (int s = 1; s < int'(LATENCY); s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_err[s]   <= pipe_err[s-1];
            pipe_rdata[s] <= pipe_rdata[s-1];
         end
      end
   end

   // Saturating count of accepted requests.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_cnt <= 32'd0;
      end else if (data_req_i && (req_cnt != 32'hFFFF_FFFF)) begin
         req_cnt <= req_cnt + 32'd1;
      end else begin
         req_cnt <= req_cnt;
      end
   end

   assign data_rvalid_o = pipe_valid[LATENCY-1];
   assign data_err_o    = pipe_err[LATENCY-1];
   assign data_rdata_o  = pipe_rdata[LATENCY-1];
   assign req_cnt_o     = req_cnt;

endmodule

// File: tb/tb_miriscv_data_ram_resp.sv
// -----------------------------------------------------------------------------
// Self-checking bench for miriscv_data_ram_resp.
//
// Three instances share one stimulus stream:
//   0: LATENCY=1, BASE=0x0000, 1024 words
//   1: LATENCY=3, BASE=0x0000, 1024 words
//   2: LATENCY=4, BASE=0x2000,  256 words
// A behavioural model keeps the byte contents of each memory and a table of
// expected responses indexed by the cycle in which each one is due.
// -----------------------------------------------------------------------------
module tb_miriscv_data_ram_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic        rv0, rv1, rv2;
   logic        er0, er1, er2;
   logic [31:0] rd0, rd1, rd2;
   logic [31:0] cn0, cn1, cn2;

   int checks = 0;
   int errors = 0;
   int n      = 0;

   // reference model state
   logic [31:0] mm   [3][1024];
   logic [3:0]  kn   [3][1024];
   logic [31:0] cnt_m[3];
   bit          ev   [3][8];
   bit          ee   [3][8];
   bit          edc  [3][8];
   logic [31:0] ed   [3][8];

   always #5 clk = ~clk;

   miriscv_data_ram_resp #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_we_i(we), .data_be_i(be),
      .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rv0), .data_rdata_o(rd0),
      .data_err_o(er0), .req_cnt_o(cn0));

   miriscv_data_ram_resp #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0000_0000)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_we_i(we), .data_be_i(be),
      .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rv1), .data_rdata_o(rd1),
      .data_err_o(er1), .req_cnt_o(cn1));

   miriscv_data_ram_resp #(.XLEN(32), .DEPTH_WORDS(256), .LATENCY(4), .BASE_ADDR(32'h0000_2000)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_we_i(we), .data_be_i(be),
      .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rv2), .data_rdata_o(rd2),
      .data_err_o(er2), .req_cnt_o(cn2));

   function automatic int lat_of(int k);
      case (k)
         0:       return 1;
         1:       return 3;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] base_of(int k);
      case (k)
         2:       return 32'h0000_2000;
         default: return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [31:0] depth_of(int k);
      case (k)
         2:       return 32'd256;
         default: return 32'd1024;
      endcase
   endfunction

   // sel: 0 rvalid, 1 err, 2 rdata, 3 req_cnt
   function automatic logic [31:0] obs(int k, int sel);
      logic [31:0] v [4];
      case (k)
         0:       begin v[0] = {31'd0, rv0}; v[1] = {31'd0, er0}; v[2] = rd0; v[3] = cn0; end
         1:       begin v[0] = {31'd0, rv1}; v[1] = {31'd0, er1}; v[2] = rd1; v[3] = cn1; end
         default: begin v[0] = {31'd0, rv2}; v[1] = {31'd0, er2}; v[2] = rd2; v[3] = cn2; end
      endcase
      return v[sel];
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, n);
      end
   endtask

   task automatic clear_slot(input int k, input int s);
      ev[k][s]  = 1'b0;
      ee[k][s]  = 1'b0;
      ed[k][s]  = 32'd0;
      edc[k][s] = 1'b1;
   endtask

   // One clock: drive inputs, update the model at the edge, then compare.
   task automatic cycle(input logic rq, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] wd, input logic rs);
      logic [31:0] off;
      bit          inr;
      int          idx;
      int          s;
      req = rq; we = w; be = b; addr = a; wdata = wd; rst = rs;
      @(posedge clk);
      n++;
      for (int k = 0; k < 3; k++) begin
         if (rs) begin
            for (int j = 0; j < 8; j++) clear_slot(k, j);
            cnt_m[k] = 32'd0;
         end else if (rq) begin
            off = a - base_of(k);
            inr = (off / 32'd4) < depth_of(k);
            idx = inr ? int'(off / 32'd4) : 0;
            s   = (n + lat_of(k) - 1) % 8;
            ev[k][s]  = 1'b1;
            ee[k][s]  = !inr;
            ed[k][s]  = 32'd0;
            edc[k][s] = 1'b1;
            if (!w && inr) begin
               ed[k][s]  = mm[k][idx];
               edc[k][s] = (kn[k][idx] == 4'hF);
            end
            if (w && inr) begin
               for (int bi = 0; bi < 4; bi++) begin
                  if (b[bi]) begin
                     mm[k][idx][8*bi +: 8] = wd[8*bi +: 8];
                     kn[k][idx][bi] = 1'b1;
                  end
               end
            end
            if (cnt_m[k] != 32'hFFFF_FFFF) cnt_m[k] = cnt_m[k] + 32'd1;
         end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         s = n % 8;
         check_val($sformatf("rvalid[%0d]", k), obs(k, 0), {31'd0, ev[k][s]});
         check_val($sformatf("err[%0d]", k),    obs(k, 1), {31'd0, ee[k][s]});
         if (edc[k][s]) check_val($sformatf("rdata[%0d]", k), obs(k, 2), ed[k][s]);
         check_val($sformatf("req_cnt[%0d]", k), obs(k, 3), cnt_m[k]);
         clear_slot(k, s);
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
   endtask

   initial begin
      logic [31:0] a;
      req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'd0; wdata = 32'd0; rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cnt_m[k] = 32'd0;
         for (int j = 0; j < 8; j++) clear_slot(k, j);
         for (int w = 0; w < 1024; w++) begin
            mm[k][w] = 32'd0;
            kn[k][w] = 4'h0;
         end
      end

      // reset for two cycles, the second one carrying a request
      cycle(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1);
      cycle(1'b1, 1'b1, 4'hF, 32'h14, 32'hCAFE_0000, 1'b1);
      idle(3);
      check_val("cnt_after_reset", cn0, 32'd0);

      // write then read back on the next cycle
      cycle(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0);
      check_val("wr_resp_valid", {31'd0, rv0}, 32'd1);
      cycle(1'b1, 1'b0, 4'h0, 32'h10, 32'd0, 1'b0);
      check_val("rd_deadbeef", rd0, 32'hDEAD_BEEF);
      check_val("cnt_two", cn0, 32'd2);

      // byte enables
      cycle(1'b1, 1'b1, 4'hF,    32'h20, 32'h1122_3344, 1'b0);
      cycle(1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, 1'b0);
      cycle(1'b1, 1'b0, 4'h0,    32'h20, 32'd0, 1'b0);
      check_val("be_merge", rd0, 32'h11BB_33DD);

      // back-to-back reads through the 3-cycle instance
      cycle(1'b1, 1'b1, 4'hF, 32'h0, 32'd1, 1'b0);
      cycle(1'b1, 1'b1, 4'hF, 32'h4, 32'd2, 1'b0);
      cycle(1'b1, 1'b1, 4'hF, 32'h8, 32'd3, 1'b0);
      idle(3);
      cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'd0, 1'b0);
      cycle(1'b1, 1'b0, 4'h0, 32'h4, 32'd0, 1'b0);
      cycle(1'b1, 1'b0, 4'h0, 32'h8, 32'd0, 1'b0);
      check_val("b2b_first", rd1, 32'd1);
      idle(1);
      check_val("b2b_second", rd1, 32'd2);
      idle(1);
      check_val("b2b_third", rd1, 32'd3);
      idle(1);
      check_val("b2b_done", {31'd0, rv1}, 32'd0);
      idle(2);

      // range boundaries
      cycle(1'b1, 1'b0, 4'h0, 32'h0000_0FFC, 32'd0, 1'b0);
      check_val("last_word_ok", {31'd0, er0}, 32'd0);
      cycle(1'b1, 1'b1, 4'hF, 32'h0000_1000, 32'hBAD0_BAD0, 1'b0);
      check_val("oor_wr_err", {31'd0, er0}, 32'd1);
      cycle(1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'd0, 1'b0);
      check_val("oor_rd_data", rd0, 32'd0);
      cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'd0, 1'b0);
      check_val("no_alias_write", rd0, 32'd1);
      idle(4);

      // reset while a write response is still in flight
      cycle(1'b1, 1'b1, 4'hF, 32'h40, 32'h5A5A_5A5A, 1'b0);
      idle(1);
      cycle(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1);
      cycle(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1);
      idle(5);
      cycle(1'b1, 1'b0, 4'h0, 32'h40, 32'd0, 1'b0);
      check_val("write_survives_reset", rd0, 32'h5A5A_5A5A);

      // a write presented during reset must not land
      cycle(1'b1, 1'b1, 4'hF, 32'h30, 32'h1234_5678, 1'b0);
      cycle(1'b1, 1'b1, 4'hF, 32'h30, 32'hFFFF_FFFF, 1'b1);
      cycle(1'b1, 1'b0, 4'h0, 32'h30, 32'd0, 1'b0);
      check_val("reset_write_ignored", rd0, 32'h1234_5678);
      idle(4);

      // preload the random windows so most reads have known data
      for (int w = 0; w < 64; w++) cycle(1'b1, 1'b1, 4'hF, 32'(w * 4), $urandom, 1'b0);
      for (int w = 0; w < 64; w++) cycle(1'b1, 1'b1, 4'hF, 32'h2000 + 32'(w * 4), $urandom, 1'b0);

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: a = 32'($urandom_range(0, 255));
            4, 5, 6:    a = 32'h2000 + 32'($urandom_range(0, 255));
            default: begin
               case ($urandom_range(0, 5))
                  0:       a = 32'h0000_0FFC;
                  1:       a = 32'h0000_1000;
                  2:       a = 32'h0000_23FC;
                  3:       a = 32'h0000_2400;
                  4:       a = 32'h0000_1FFC;
                  default: a = 32'hFFFF_FFFC;
               endcase
            end
         endcase
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
               a, $urandom, $urandom_range(0, 99) < 2);
      end
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
